// File: rtl/mem_load_run_check.sv
// Load/run/check sequencer for the processor external memory port: streams a program
// image in with the CPU paused, lets it run for a fixed time, then reads back and compares results.
module mem_load_run_check #(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter int         LOAD_BASE   = 1024,
  parameter int         LOAD_WORDS  = 16384,
  parameter int         RUN_CYCLES  = 200,
  parameter int         CHECK_BASE  = 20000,
  parameter int         CHECK_WORDS = 50,
  parameter int         RD_LAT      = 1,
  parameter int         CNT_W       = 16,
  parameter logic [2:0] MODE_NONE   = 3'd0,
  parameter logic [2:0] MODE_WORD   = 3'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  output logic              pause,
  output logic              externalMemoryControl,
  output logic [ADDR_W-1:0] externalAddress,
  output logic [DATA_W-1:0] externalData,
  output logic [2:0]        externalReadMode,
  output logic [2:0]        externalWriteMode,
  input  logic [DATA_W-1:0] externalDataOut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_fail_index,
  output logic [DATA_W-1:0] first_fail_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CHK_ADDR, S_CHK_WAIT, S_CHK_CMP, S_DONE
  } state_t;

  state_t r_state, w_next;

  // r_cnt is shared: load word index, run cycle count, read-latency wait count
  logic [31:0]       r_cnt;
  logic [31:0]       r_j;
  logic [CNT_W-1:0]  r_mm;
  logic [CNT_W-1:0]  r_ffi;
  logic [DATA_W-1:0] r_ffd;
  logic              r_abort;

  logic              w_load_last, w_run_last, w_wait_last, w_chk_last, w_miss, w_go;
  logic [ADDR_W-1:0] w_ld_addr, w_ck_addr;

  assign w_load_last = (r_cnt == 32'(LOAD_WORDS - 1));
  assign w_run_last  = (r_cnt == 32'(RUN_CYCLES - 1));
  assign w_wait_last = (r_cnt == 32'(RD_LAT - 1));
  assign w_chk_last  = (r_j   == 32'(CHECK_WORDS - 1));
  assign w_miss      = (externalDataOut != exp_data);
  assign w_go        = start && !abort;
  assign w_ld_addr   = ADDR_W'(LOAD_BASE)  + ADDR_W'({r_cnt, 2'b00});
  assign w_ck_addr   = ADDR_W'(CHECK_BASE) + ADDR_W'({r_j, 2'b00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_j     <= '0;
      r_mm    <= '0;
      r_ffi   <= '0;
      r_ffd   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go) begin
            r_cnt   <= '0;
            r_j     <= '0;
            r_mm    <= '0;
            r_ffi   <= '0;
            r_ffd   <= '0;
            r_abort <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort)           r_abort <= 1'b1;
          else if (load_valid) r_cnt   <= w_load_last ? '0 : r_cnt + 32'd1;
        end
        S_RUN: begin
          if (abort) r_abort <= 1'b1;
          else       r_cnt   <= w_run_last ? '0 : r_cnt + 32'd1;
        end
        S_CHK_ADDR: begin
          if (abort) r_abort <= 1'b1;
          else       r_cnt   <= '0;
        end
        S_CHK_WAIT: begin
          if (abort) r_abort <= 1'b1;
          else       r_cnt   <= r_cnt + 32'd1;
        end
        S_CHK_CMP: begin
          if (abort) r_abort <= 1'b1;
          else if (exp_valid) begin
            if (w_miss) begin
              if (r_mm != '1) r_mm <= r_mm + 1'b1;
              if (r_mm == '0) begin
                r_ffi <= CNT_W'(r_j);
                r_ffd <= externalDataOut;
              end
            end
            r_j <= r_j + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_go) w_next = (LOAD_WORDS == 0) ? S_RUN : S_LOAD;
      S_LOAD:     if (abort) w_next = S_DONE;
                  else if (load_valid && w_load_last) w_next = S_RUN;
      S_RUN:      if (abort) w_next = S_DONE;
                  else if (w_run_last) w_next = (CHECK_WORDS == 0) ? S_DONE : S_CHK_ADDR;
      S_CHK_ADDR: w_next = abort ? S_DONE : S_CHK_WAIT;
      S_CHK_WAIT: if (abort) w_next = S_DONE;
                  else if (w_wait_last) w_next = S_CHK_CMP;
      S_CHK_CMP:  if (abort) w_next = S_DONE;
                  else if (exp_valid) w_next = w_chk_last ? S_DONE : S_CHK_ADDR;
      default:    w_next = S_IDLE;
    endcase
  end

  // Port outputs are decoded from state so an async reset takes effect immediately
  always_comb begin
    pause                 = 1'b1;
    externalMemoryControl = 1'b1;
    externalAddress       = '0;
    externalData          = '0;
    externalReadMode      = MODE_NONE;
    externalWriteMode     = MODE_NONE;
    load_ready            = 1'b0;
    exp_ready             = 1'b0;
    busy                  = 1'b0;
    done                  = 1'b0;
    case (r_state)
      S_LOAD: begin
        busy            = 1'b1;
        load_ready      = 1'b1;
        externalAddress = w_ld_addr;
        externalData    = load_data;
        if (load_valid) externalWriteMode = MODE_WORD;
      end
      S_RUN: begin
        busy                  = 1'b1;
        pause                 = 1'b0;
        externalMemoryControl = 1'b0;
      end
      S_CHK_ADDR, S_CHK_WAIT, S_CHK_CMP: begin
        busy             = 1'b1;
        externalAddress  = w_ck_addr;
        externalReadMode = MODE_WORD;
        exp_ready        = (r_state == S_CHK_CMP);
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign pass             = done && !r_abort && (r_mm == '0);
  assign mismatch_count   = r_mm;
  assign first_fail_index = r_ffi;
  assign first_fail_data  = r_ffd;

endmodule

// File: tb/tb_mem_load_run_check.sv
// Bench for mem_load_run_check: scoreboarded program writes and read-back addresses,
// read-latency memory model, corrupted result words, abort and mid-check reset.
module tb_mem_load_run_check;
  localparam int AW = 32, DW = 32, LW = 4, RC = 200, LB = 1024, CB = 20000;
  localparam int CW = 50, RL = 2, CNTW = 16;
  localparam logic [2:0] M_NONE = 3'd0, M_WORD = 3'd3;

  logic clk = 1'b0;
  logic rst, start, abort, load_valid, load_ready, exp_valid, exp_ready;
  logic [DW-1:0] load_data, exp_data, wdata, rdata, ffd;
  logic pause, ctl, busy, done, pass;
  logic [AW-1:0] addr;
  logic [2:0] rmode, wmode;
  logic [CNTW-1:0] mm, ffi;

  always #5 clk = ~clk;

  mem_load_run_check #(
    .ADDR_W(AW), .DATA_W(DW), .LOAD_BASE(LB), .LOAD_WORDS(LW), .RUN_CYCLES(RC),
    .CHECK_BASE(CB), .CHECK_WORDS(CW), .RD_LAT(RL), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .pause(pause), .externalMemoryControl(ctl), .externalAddress(addr),
    .externalData(wdata), .externalReadMode(rmode), .externalWriteMode(wmode),
    .externalDataOut(rdata), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mm), .first_fail_index(ffi), .first_fail_data(ffd)
  );

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // result memory with RL-cycle read pipeline; words 7 and 12 optionally corrupted
  logic [DW-1:0] res_mem [CW];
  logic [DW-1:0] ld_words [LW];
  logic [AW-1:0] apipe [RL];
  logic [31:0]   w_idx;
  bit corrupt = 0;

  always @(posedge clk) begin
    apipe[0] <= addr;
    for (int k = 1; k < RL; k++) apipe[k] <= apipe[k-1];
  end

  always_comb begin
    w_idx = (apipe[RL-1] - CB) >> 2;
    rdata = '0;
    if (apipe[RL-1] >= CB && w_idx < CW)
      rdata = (corrupt && (w_idx == 7 || w_idx == 12)) ? 32'hDEADBEEF : res_mem[w_idx];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wq[$];

  int ld_ptr = 0, ep = 0, stall_at = -1, stall_left = 0, run_cnt = 0, wr_cnt = 0;
  bit ld_fire = 0, ex_fire = 0, gaps = 0, stalled = 0;

  // drive at negedge, sample DUT outputs 1ns later within the same low phase
  always @(negedge clk) begin
    wr_t e;
    if (ld_fire) ld_ptr++;
    if (ex_fire) ep++;
    load_valid = 1'b0;
    stalled    = 1'b0;
    if (load_ready === 1'b1 && ld_ptr < LW) begin
      if (ld_ptr == stall_at && stall_left > 0) begin
        stall_left--;
        stalled = 1'b1;
      end else begin
        load_valid = 1'b1;
        load_data  = ld_words[ld_ptr];
        e.a = AW'(LB + 4 * ld_ptr);
        e.d = ld_words[ld_ptr];
        wq.push_back(e);
      end
    end
    exp_valid = 1'b0;
    if (ep < CW && (!gaps || $urandom_range(3) != 0)) begin
      exp_valid = 1'b1;
      exp_data  = res_mem[ep];
    end
    #1;
    ld_fire = load_valid && load_ready;
    ex_fire = exp_valid && exp_ready;
    if (!rst) begin
      if (wmode == M_WORD) begin
        wr_cnt++;
        if (wq.size() == 0) chk("spurious_write", wmode, M_NONE);
        else begin
          e = wq.pop_front();
          chk("wr_addr", addr, e.a);
          chk("wr_data", wdata, e.d);
        end
      end else if (load_valid) chk("missing_write", wmode, M_WORD);
      if (stalled) begin
        chk("stall_mode", wmode, M_NONE);
        chk("stall_addr", addr, LB + 4 * ld_ptr);
      end
      if (pause === 1'b0) begin
        run_cnt++;
        chk("run_ctl", ctl, 1'b0);
      end
      if (rmode == M_WORD && ep < CW) chk("rd_addr", addr, CB + 4 * ep);
    end
  end

  task automatic wait_done(input int lim);
    int k = 0;
    while (done !== 1'b1 && k < lim) begin
      @(negedge clk); #2;
      k++;
    end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic begin_seq(input int stall, input bit corr, input bit gp);
    @(negedge clk); #2;
    ld_ptr = 0; ep = 0; ld_fire = 0; ex_fire = 0;
    stall_at = stall; stall_left = (stall >= 0) ? 3 : 0;
    corrupt = corr; gaps = gp; run_cnt = 0; wr_cnt = 0;
    wq.delete();
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic end_checks(input string tag, input bit exp_pass, input int exp_mm,
                            input int exp_ffi, input logic [DW-1:0] exp_ffd);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_mm"}, mm, exp_mm);
    chk({tag, "_ffi"}, ffi, exp_ffi);
    chk({tag, "_ffd"}, ffd, exp_ffd);
    chk({tag, "_run_cycles"}, run_cnt, RC);
    chk({tag, "_writes"}, wr_cnt, LW);
    chk({tag, "_wq_empty"}, wq.size(), 0);
    chk({tag, "_reads"}, ep, CW);
    chk({tag, "_idle_port"}, {busy, pause, ctl, rmode, wmode}, {1'b0, 1'b1, 1'b1, M_NONE, M_NONE});
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    load_valid = 1'b0; load_data = '0; exp_valid = 1'b0; exp_data = '0;
    for (int i = 0; i < LW; i++) ld_words[i] = 32'hA0 + i;
    for (int i = 0; i < CW; i++) res_mem[i] = $urandom();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_port", {pause, ctl, rmode, wmode, busy, done, pass, load_ready, exp_ready},
        {1'b1, 1'b1, M_NONE, M_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_cnt", {addr, wdata, mm, ffi, ffd}, '0);
    rst = 1'b0;

    // clean run, back-to-back program words
    begin_seq(-1, 0, 0);
    wait_done(3000);
    end_checks("clean", 1'b1, 0, 0, '0);

    // mid-stream load stall, corrupted words 7/12, exp_valid gaps
    begin_seq(2, 1, 1);
    wait_done(4000);
    end_checks("corrupt", 1'b0, 2, 7, 32'hDEADBEEF);

    // abort while running
    begin_seq(-1, 0, 0);
    k = 0;
    while (pause !== 1'b0 && k < 100) begin @(negedge clk); #2; k++; end
    chk("run_reached", pause, 1'b0);
    repeat (5) begin @(negedge clk); #2; end
    abort = 1'b1;
    @(negedge clk); #2;
    abort = 1'b0;
    chk("abort_state", {done, pass, pause, ctl, busy}, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0});

    // async reset inside CHK_WAIT after two mismatches were recorded
    begin_seq(-1, 1, 0);
    k = 0;
    while (!(rmode == M_WORD && ep == 13) && k < 2000) begin @(negedge clk); #2; k++; end
    chk("chk13_reached", ep, 13);
    chk("pre_rst_mm", mm, 2);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_port", {pause, ctl, rmode, wmode, busy, done}, {1'b1, 1'b1, M_NONE, M_NONE, 1'b0, 1'b0});
    chk("midrst_cnt", {mm, ffi, ffd, addr}, '0);
    @(negedge clk); #2;
    rst = 1'b0;

    // start and abort together in IDLE: no sequence begins
    start = 1'b1; abort = 1'b1;
    @(negedge clk); #2;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {busy, done, pause, load_ready}, {1'b0, 1'b0, 1'b1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
